cdb_arbiter: RTL and testbench

CDB_ARBITER -- requirements
Module: cdb_arbiter

---
 rtl/cdb_arbiter_pkg.sv | 17 +
 rtl/cdb_arbiter_fifo2.sv | 58 +++++
 rtl/cdb_arbiter.sv | 109 ++++++++++
 tb/tb_cdb_arbiter.sv | 239 +++++++++++++++++++++++
 4 files changed

// File: rtl/cdb_arbiter_pkg.sv
// cdb_arbiter_pkg
//   Shared constants for the common data bus arbiter: functional-unit index
//   encodings (matching ALUSel), default widths and the mod-3 index step.
package cdb_arbiter_pkg;
  localparam int NUM_FU     = 3;
  localparam int DATA_W_DEF = 32;
  localparam int TAG_W_DEF  = 4;

  localparam logic [1:0] FU_ADD = 2'd0;
  localparam logic [1:0] FU_MUL = 2'd1;
  localparam logic [1:0] FU_DIV = 2'd2;

  // Next unit index, wrapping DIV back to ADD.
  function automatic logic [1:0] fu_next(input logic [1:0] idx);
    return (idx == FU_DIV) ? FU_ADD : idx + 2'd1;
  endfunction
endpackage

// File: rtl/cdb_arbiter_fifo2.sv
// cdb_fifo2
//   Two-entry result buffer for one functional unit.
//   i_push/i_pop : enqueue i_din / dequeue head (both may fire together)
//   i_flush      : synchronous clear, beats a same-cycle push
//   o_dout       : head entry; o_count/o_full/o_empty : occupancy
module cdb_fifo2 #(
  parameter int W = 36
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         i_flush,
  input  logic         i_push,
  input  logic         i_pop,
  input  logic [W-1:0] i_din,
  output logic [W-1:0] o_dout,
  output logic [1:0]   o_count,
  output logic         o_full,
  output logic         o_empty
);
  logic [W-1:0] r_mem [2];
  logic         r_wptr, r_rptr;
  logic [1:0]   r_cnt;
  logic         w_push, w_pop;

  assign o_full  = (r_cnt == 2'd2);
  assign o_empty = (r_cnt == 2'd0);
  assign o_count = r_cnt;
  assign o_dout  = r_mem[r_rptr];

  // A pop on an empty buffer is legal only alongside a push: the entry is
  // written and consumed in the same cycle (the caller bypasses i_din).
  assign w_push = i_push & ~o_full & ~i_flush;
  assign w_pop  = i_pop & (~o_empty | w_push) & ~i_flush;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else if (i_flush) begin
      r_wptr <= 1'b0;
      r_rptr <= 1'b0;
      r_cnt  <= 2'd0;
    end else begin
      if (w_push) r_wptr <= ~r_wptr;
      if (w_pop)  r_rptr <= ~r_rptr;
      case ({w_push, w_pop})
        2'b10:   r_cnt <= r_cnt + 2'd1;
        2'b01:   r_cnt <= r_cnt - 2'd1;
        default: r_cnt <= r_cnt;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_push) r_mem[r_wptr] <= i_din;
  end
endmodule

// File: rtl/cdb_arbiter.sv
// cdb_arbiter
//   Buffers results from the add/sub, multiply and divide units (one 2-entry
//   FIFO each) and broadcasts one per cycle on the CDB, round-robin.
//   clk, rst (async high), flush (sync clear)
//   fu_valid/fu_tag/fu_data in, fu_ready out : per-unit result handshake
//   cdb_valid/cdb_tag/cdb_data/cdb_src       : registered broadcast
//   fu_pending                               : per-unit buffer non-empty
module cdb_arbiter
  import cdb_arbiter_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int TAG_W  = TAG_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [2:0]            fu_valid,
  input  logic [3*TAG_W-1:0]    fu_tag,
  input  logic [3*DATA_W-1:0]   fu_data,
  output logic [2:0]            fu_ready,
  output logic                  cdb_valid,
  output logic [TAG_W-1:0]      cdb_tag,
  output logic [DATA_W-1:0]     cdb_data,
  output logic [1:0]            cdb_src,
  output logic [2:0]            fu_pending
);
  localparam int EW = TAG_W + DATA_W;

  logic [2:0]    w_push, w_pop, w_full, w_empty, w_cand;
  logic [EW-1:0] w_din  [NUM_FU];
  logic [EW-1:0] w_dout [NUM_FU];
  logic [EW-1:0] w_head [NUM_FU];
  logic [1:0]    w_cnt  [NUM_FU];

  logic [1:0]        r_rr;
  logic              r_cdb_valid;
  logic [TAG_W-1:0]  r_cdb_tag;
  logic [DATA_W-1:0] r_cdb_data;
  logic [1:0]        r_cdb_src;

  logic              w_gnt_vld;
  logic [1:0]        w_gnt_idx, w_idx;

  for (genvar g = 0; g < NUM_FU; g++) begin : g_fu
    assign w_din[g]      = {fu_tag[g*TAG_W +: TAG_W], fu_data[g*DATA_W +: DATA_W]};
    assign w_push[g]     = fu_valid[g] & ~w_full[g] & ~flush;
    assign fu_ready[g]   = (w_cnt[g] < 2'd2);
    assign fu_pending[g] = (w_cnt[g] != 2'd0);
    // An empty buffer taking a result this cycle competes with it directly,
    // giving single-cycle acceptance-to-broadcast latency.
    assign w_cand[g]     = ~w_empty[g] | w_push[g];
    assign w_head[g]     = w_empty[g] ? w_din[g] : w_dout[g];

    cdb_fifo2 #(.W(EW)) u_fifo (
      .clk     (clk),
      .rst     (rst),
      .i_flush (flush),
      .i_push  (w_push[g]),
      .i_pop   (w_pop[g]),
      .i_din   (w_din[g]),
      .o_dout  (w_dout[g]),
      .o_count (w_cnt[g]),
      .o_full  (w_full[g]),
      .o_empty (w_empty[g])
    );
  end

  // Round-robin search starting at r_rr, upward modulo 3.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = r_rr;
    w_idx     = r_rr;
    for (int k = 0; k < NUM_FU; k++) begin
      if (!w_gnt_vld && w_cand[w_idx]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_idx;
      end
      w_idx = fu_next(w_idx);
    end
  end

  assign w_pop = (w_gnt_vld && !flush) ? (3'b001 << w_gnt_idx) : 3'b000;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rr        <= FU_ADD;
      r_cdb_valid <= 1'b0;
      r_cdb_tag   <= '0;
      r_cdb_data  <= '0;
      r_cdb_src   <= 2'd0;
    end else if (flush) begin
      r_rr        <= FU_ADD;
      r_cdb_valid <= 1'b0;
    end else begin
      r_cdb_valid <= w_gnt_vld;
      if (w_gnt_vld) begin
        r_rr       <= fu_next(w_gnt_idx);
        r_cdb_tag  <= w_head[w_gnt_idx][EW-1 -: TAG_W];
        r_cdb_data <= w_head[w_gnt_idx][DATA_W-1:0];
        r_cdb_src  <= w_gnt_idx;
      end
    end
  end

  assign cdb_valid = r_cdb_valid;
  assign cdb_tag   = r_cdb_tag;
  assign cdb_data  = r_cdb_data;
  assign cdb_src   = r_cdb_src;
endmodule

// File: tb/tb_cdb_arbiter.sv
module tb_cdb_arbiter;
  localparam int DATA_W = 32;
  localparam int TAG_W  = 4;
  localparam int EW     = TAG_W + DATA_W;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic                flush = 1'b0;
  logic [2:0]          fu_valid = '0;
  logic [3*TAG_W-1:0]  fu_tag = '0;
  logic [3*DATA_W-1:0] fu_data = '0;
  logic [2:0]          fu_ready, fu_pending;
  logic                cdb_valid;
  logic [TAG_W-1:0]    cdb_tag;
  logic [DATA_W-1:0]   cdb_data;
  logic [1:0]          cdb_src;

  cdb_arbiter #(.DATA_W(DATA_W), .TAG_W(TAG_W)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .fu_valid(fu_valid), .fu_tag(fu_tag), .fu_data(fu_data),
    .fu_ready(fu_ready), .cdb_valid(cdb_valid), .cdb_tag(cdb_tag),
    .cdb_data(cdb_data), .cdb_src(cdb_src), .fu_pending(fu_pending)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h exp %0h", tag, got, exp);
    end
  endtask

  // Per-unit scoreboard of accepted results, in acceptance order.
  logic [EW-1:0] q0[$], q1[$], q2[$];

  task automatic sb_clear();
    q0.delete(); q1.delete(); q2.delete();
  endtask

  task automatic sb_push(input int u, input logic [EW-1:0] e);
    case (u)
      0: q0.push_back(e);
      1: q1.push_back(e);
      default: q2.push_back(e);
    endcase
  endtask

  // Next result each unit will present; a unit keeps presenting the same
  // result until it is accepted.
  int             seq   [3];
  logic [TAG_W-1:0]  t_tag [3];
  logic [DATA_W-1:0] t_dat [3];

  task automatic reload(input int u);
    t_tag[u] = TAG_W'(seq[u] * 3 + u);
    t_dat[u] = 32'h1000_0000 * (u + 1) + 32'(seq[u]);
  endtask

  task automatic drive();
    fu_tag  = {t_tag[2], t_tag[1], t_tag[0]};
    fu_data = {t_dat[2], t_dat[1], t_dat[0]};
  endtask

  // Called at a negedge; returns at the next negedge.
  task automatic step(input logic [2:0] v, input logic fl);
    logic [2:0] acc;
    fu_valid = v;
    flush    = fl;
    drive();
    acc = (fl ? 3'b000 : v & fu_ready);
    for (int i = 0; i < 3; i++)
      if (acc[i]) begin
        sb_push(i, {t_tag[i], t_dat[i]});
        seq[i]++;
        reload(i);
      end
    @(posedge clk);
    @(negedge clk);
    fu_valid = '0;
    flush    = 1'b0;
  endtask

  // Every broadcast must match the oldest outstanding result of its unit.
  always @(negedge clk) begin
    logic [EW-1:0] e;
    if (!rst && cdb_valid) begin
      if (cdb_src > 2'd2) chk("cdb_src_range", {62'd0, cdb_src}, 64'd0);
      else if ((cdb_src == 0 && q0.size() == 0) || (cdb_src == 1 && q1.size() == 0) ||
               (cdb_src == 2 && q2.size() == 0))
        chk("spurious_bcast", 64'(cdb_src) + 64'd1, 64'd0);
      else begin
        case (cdb_src)
          2'd0:    e = q0.pop_front();
          2'd1:    e = q1.pop_front();
          default: e = q2.pop_front();
        endcase
        chk("sb_tag",  64'(cdb_tag),  64'(e[EW-1 -: TAG_W]));
        chk("sb_data", 64'(cdb_data), 64'(e[DATA_W-1:0]));
      end
    end
  end

  task automatic drain(input string tag);
    int n;
    n = 0;
    while ((fu_pending != 3'b000 || cdb_valid) && n < 20) begin
      step(3'b000, 1'b0);
      n++;
    end
    chk(tag, 64'(fu_pending), 64'd0);
    chk({tag, "_q"}, 64'(q0.size() + q1.size() + q2.size()), 64'd0);
  endtask

  int s1, k;

  initial begin
    for (int i = 0; i < 3; i++) begin seq[i] = 0; reload(i); end
    drive();

    // Reset state
    @(negedge clk); @(negedge clk);
    chk("rst_valid",   64'(cdb_valid),  64'd0);
    chk("rst_tag",     64'(cdb_tag),    64'd0);
    chk("rst_data",    64'(cdb_data),   64'd0);
    chk("rst_src",     64'(cdb_src),    64'd0);
    chk("rst_ready",   64'(fu_ready),   64'h7);
    chk("rst_pending", 64'(fu_pending), 64'h0);
    rst = 1'b0;

    // Single add/sub result: tag 3, data 0x11
    t_tag[0] = 4'd3; t_dat[0] = 32'h11;
    step(3'b001, 1'b0);
    chk("t1_valid", 64'(cdb_valid), 64'd1);
    chk("t1_tag",   64'(cdb_tag),   64'd3);
    chk("t1_data",  64'(cdb_data),  64'h11);
    chk("t1_src",   64'(cdb_src),   64'd0);
    step(3'b000, 1'b0);
    chk("t1_idle",  64'(cdb_valid), 64'd0);
    chk("t1_hold",  64'(cdb_tag),   64'd3);

    // All three units at once from rr_ptr=0
    step(3'b000, 1'b1); sb_clear();
    step(3'b111, 1'b0);
    chk("rr_a", {63'd0, cdb_valid, 2'b0} | 64'(cdb_src), 64'h4);
    step(3'b000, 1'b0);
    chk("rr_b", {63'd0, cdb_valid, 2'b0} | 64'(cdb_src), 64'h5);
    step(3'b000, 1'b0);
    chk("rr_c", {63'd0, cdb_valid, 2'b0} | 64'(cdb_src), 64'h6);
    step(3'b000, 1'b0);
    chk("rr_idle", 64'(cdb_valid), 64'd0);
    // rr_ptr wrapped to 0: add wins over multiply
    step(3'b011, 1'b0);
    chk("rr_wrap0", 64'(cdb_src), 64'd0);
    step(3'b000, 1'b0);
    chk("rr_wrap1", 64'(cdb_src), 64'd1);
    drain("rr_drain");

    // Back-pressure: all units streaming, multiply fills up
    step(3'b000, 1'b1); sb_clear();
    chk("bp_rdy_a", 64'(fu_ready), 64'h7); step(3'b111, 1'b0);
    chk("bp_rdy_b", 64'(fu_ready), 64'h7); step(3'b111, 1'b0);
    chk("bp_rdy_c", 64'(fu_ready), 64'h3); step(3'b111, 1'b0);
    chk("bp_rdy_d", 64'(fu_ready), 64'h4);
    s1 = seq[1];
    step(3'b111, 1'b0);
    chk("bp_mul_held_d", 64'(seq[1]), 64'(s1));
    chk("bp_rdy_e", 64'(fu_ready), 64'h1);
    step(3'b010, 1'b0);
    chk("bp_mul_held_e", 64'(seq[1]), 64'(s1));
    chk("bp_rdy_f", 64'(fu_ready), 64'h3);
    step(3'b010, 1'b0);
    chk("bp_mul_acc_f", 64'(seq[1]), 64'(s1 + 1));
    drain("bp_drain");

    // Flush with buffers at their fullest, plus a same-cycle offer
    step(3'b000, 1'b1); sb_clear();
    for (int i = 0; i < 4; i++) step(3'b111, 1'b0);
    chk("fl_pre_pend", 64'(fu_pending), 64'h7);
    step(3'b111, 1'b1);
    sb_clear();
    chk("fl_valid",   64'(cdb_valid),  64'd0);
    chk("fl_pending", 64'(fu_pending), 64'h0);
    chk("fl_ready",   64'(fu_ready),   64'h7);
    step(3'b000, 1'b0);
    chk("fl_dropped", 64'(cdb_valid),  64'd0);

    // Async reset between edges with a result in flight
    step(3'b010, 1'b0);
    chk("ar_pre_src", 64'(cdb_src), 64'd1);
    drive();
    fu_valid = 3'b010;
    #2 rst = 1'b1;
    sb_clear();
    #1;
    chk("ar_valid", 64'(cdb_valid), 64'd0);
    chk("ar_tag",   64'(cdb_tag),   64'd0);
    chk("ar_data",  64'(cdb_data),  64'd0);
    chk("ar_src",   64'(cdb_src),   64'd0);
    chk("ar_ready", 64'(fu_ready),  64'h7);
    @(negedge clk);
    rst = 1'b0; fu_valid = '0;
    chk("ar_pending", 64'(fu_pending), 64'h0);
    chk("ar_valid2",  64'(cdb_valid),  64'd0);
    step(3'b110, 1'b0);
    chk("ar_first_src", {63'd0, cdb_valid, 2'b0} | 64'(cdb_src), 64'h5);
    step(3'b000, 1'b0);
    chk("ar_second_src", 64'(cdb_src), 64'd2);
    drain("ar_drain");

    // Fairness: divide always valid, add/sub offers one result
    step(3'b000, 1'b1); sb_clear();
    for (int i = 0; i < 3; i++) step(3'b100, 1'b0);
    s1 = seq[0];
    step(3'b101, 1'b0);
    chk("fair_acc", 64'(seq[0]), 64'(s1 + 1));
    k = 1;
    while (!(cdb_valid && cdb_src == 2'd0) && k < 4) begin
      step(3'b100, 1'b0);
      k++;
    end
    chk("fair_within2", 64'(k <= 2), 64'd1);
    step(3'b100, 1'b0);
    drain("fair_drain");

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #50000;
    $display("FAIL timeout: got running exp finished");
    $fatal(1);
  end
endmodule
